// File: rtl/p4_router_pkg.sv
// Shared p4_router definitions: queue geometry and dequeue scheduler states.
package p4_router_pkg;

    localparam int NUM_QUEUES_PER_EGR_PORT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/p4_router_rr_arbiter.sv
// Rotating-priority picker: first requester strictly after ptr, with wrap.
module p4_router_rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int i = 1; i <= N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/p4_router_dequeue_scheduler.sv
// Picks the next queue to dequeue: round-robin over egress ports,
// strict priority over queues within the chosen port; one packet in flight.
module p4_router_dequeue_scheduler #(
    parameter int NUM_EGR_PORTS           = 4,
    parameter int NUM_QUEUES_PER_EGR_PORT = p4_router_pkg::NUM_QUEUES_PER_EGR_PORT,
    parameter int WAIT_TIMEOUT_CYCLES     = 4096,
    localparam int NUM_QUEUES = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
    localparam int QID_W      = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     sched_enable,
    input  logic [NUM_QUEUES-1:0]    queue_enable,
    input  logic [NUM_QUEUES-1:0]    queue_nonempty,
    input  logic [NUM_EGR_PORTS-1:0] egr_buf_ready,
    output logic                     deq_req_valid,
    input  logic                     deq_req_ready,
    output logic [QID_W-1:0]         deq_req_qid,
    input  logic                     deq_done,
    output logic                     sched_busy,
    output logic                     timeout_err,
    output logic                     protocol_err
);

    import p4_router_pkg::sched_state_t;
    import p4_router_pkg::IDLE;
    import p4_router_pkg::REQ;
    import p4_router_pkg::WAIT;

    localparam int Q      = NUM_QUEUES_PER_EGR_PORT;
    localparam int PORT_W = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1;
    localparam int PRIO_W = (Q > 1) ? $clog2(Q) : 1;
    localparam int WD_W   = $clog2(WAIT_TIMEOUT_CYCLES + 1);

    sched_state_t state_q, state_d;
    logic              valid_q, valid_d;
    logic [QID_W-1:0]  qid_q, qid_d;
    logic [PORT_W-1:0] port_q, port_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              timeout_q, timeout_d;
    logic              proto_q, proto_d;

    logic [NUM_QUEUES-1:0]    avail;
    logic [NUM_EGR_PORTS-1:0] port_elig;
    logic [NUM_EGR_PORTS-1:0] port_gnt;
    logic [PORT_W-1:0]        sel_port;
    logic                     any_elig;
    logic [Q-1:0]             sel_slice;
    logic [PRIO_W-1:0]        sel_prio;
    logic [QID_W-1:0]         sel_qid;

    assign avail = queue_nonempty & queue_enable;

    always_comb begin
        port_elig = '0;
        for (int p = 0; p < NUM_EGR_PORTS; p++) begin
            port_elig[p] = egr_buf_ready[p] && (|avail[p*Q +: Q]);
        end
    end

    p4_router_rr_arbiter #(.N(NUM_EGR_PORTS)) u_port_arb (
        .req (port_elig),
        .ptr (rr_ptr_q),
        .gnt (port_gnt),
        .idx (sel_port),
        .any (any_elig)
    );

    // One-hot mux of the granted port's queues, then lowest index wins.
    always_comb begin
        sel_slice = '0;
        for (int p = 0; p < NUM_EGR_PORTS; p++) begin
            if (port_gnt[p]) sel_slice = sel_slice | avail[p*Q +: Q];
        end
        sel_prio = '0;
        for (int q = Q - 1; q >= 0; q--) begin
            if (sel_slice[q]) sel_prio = PRIO_W'(q);
        end
        sel_qid = QID_W'(int'(sel_port) * Q + int'(sel_prio));
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        qid_d     = qid_q;
        port_d    = port_q;
        rr_ptr_d  = rr_ptr_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        proto_d   = deq_done && (state_q != WAIT);
        unique case (state_q)
            IDLE: begin
                if (sched_enable && any_elig) begin
                    qid_d   = sel_qid;
                    port_d  = sel_port;
                    valid_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (deq_req_ready) begin
                    valid_d  = 1'b0;
                    rr_ptr_d = port_q;
                    wd_d     = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (deq_done) begin
                    state_d = IDLE;
                end else if (wd_q == WD_W'(WAIT_TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            qid_q     <= '0;
            port_q    <= '0;
            rr_ptr_q  <= PORT_W'(NUM_EGR_PORTS - 1);
            wd_q      <= '0;
            timeout_q <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            qid_q     <= qid_d;
            port_q    <= port_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            proto_q   <= proto_d;
        end
    end

    assign deq_req_valid = valid_q;
    assign deq_req_qid   = qid_q;
    assign sched_busy    = (state_q != IDLE);
    assign timeout_err   = timeout_q;
    assign protocol_err  = proto_q;

endmodule
